// File: rtl/fir_stream_pkg.sv
// Shared types and arithmetic helpers for the fir_stream_mac FIR stage.
// The narrowing variant used by the top is selected with FIR_STREAM_SAT_EN
// (defined: saturate, undefined: two's-complement wrap).
package fir_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2
    } state_t;

    // Working width for the rounding/narrowing helpers; must cover ACC_W+1.
    localparam int CALC_W = 64;

    // Full-precision accumulator width: no overflow over TAPS products.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Round-half-up then arithmetic shift right by frac.
    function automatic logic signed [CALC_W-1:0] round_half_up(
        input logic signed [CALC_W-1:0] v,
        input int                       frac
    );
        logic signed [CALC_W-1:0] half;
        if (frac > 0) begin
            half = 64'sd1 <<< (frac - 1);
        end else begin
            half = 64'sd0;
        end
        return (v + half) >>> frac;
    endfunction

    // Keep the low out_w bits, sign-extended back to CALC_W.
    function automatic logic signed [CALC_W-1:0] narrow_wrap(
        input logic signed [CALC_W-1:0] v,
        input int                       out_w
    );
        return (v <<< (CALC_W - out_w)) >>> (CALC_W - out_w);
    endfunction

    // Clamp to the signed out_w range.
    function automatic logic signed [CALC_W-1:0] narrow_sat(
        input logic signed [CALC_W-1:0] v,
        input int                       out_w
    );
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/fir_stream_mac_unit.sv
// Time-multiplexed MAC: registered signed multiply feeding an accumulator.
// sum exposes acc plus the product still sitting in the multiplier register,
// so the final tap is folded in without an extra pipeline cycle.
module fir_stream_mac_unit #(
    parameter int A_W   = 16,
    parameter int B_W   = 18,
    parameter int ACC_W = 39
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] sum
);

    localparam int PW = A_W + B_W;

    logic signed [PW-1:0]    prod;
    logic                    prod_vld;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_ext;

    // Multiplier register and accumulator; clr drops any pending product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
        end else if (clr) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
        end else begin
            prod_vld <= en;
            if (en) begin
                prod <= PW'(a) * PW'(b);
            end
            if (prod_vld) begin
                acc <= acc + prod_ext;
            end
        end
    end

    // Sign-extended pending product, zero when nothing is in flight.
    always_comb begin
        prod_ext = '0;
        if (prod_vld) begin
            prod_ext = ACC_W'(prod);
        end
        sum = acc + prod_ext;
    end

endmodule

// File: rtl/fir_stream_mac.sv
// Streaming real FIR with runtime coefficients and one shared MAC.
// One sample per TAPS+2 cycles: IDLE accept, TAPS MAC cycles, ROUND.
// FIR_STREAM_SAT_EN selects saturating output narrowing (default: wrap).
module fir_stream_mac
    import fir_stream_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 18,
    parameter int FRAC   = 16,
    parameter int TAPS   = 32,
    parameter int OUT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       data_valid,
    input  logic signed [DATA_W-1:0]   data,
    output logic                       in_ready,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_wdata,
    output logic signed [OUT_W-1:0]    fir_d,
    output logic                       fir_valid,
    output logic                       warm
);

    localparam int AW    = $clog2(TAPS);
    localparam int CW    = AW + 1;
    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);

    state_t state;
    state_t state_nxt;

    logic [AW-1:0]            k;
    logic [AW-1:0]            wptr;
    logic [AW-1:0]            rd_idx;
    logic [CW-1:0]            cnt;
    logic signed [DATA_W-1:0] sbuf [TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];

    logic                     accept;
    logic                     coef_wr;
    logic                     mac_en;
    logic                     mac_clr;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [COEF_W-1:0] mac_b;
    logic signed [ACC_W-1:0]  mac_sum;
    logic signed [CALC_W-1:0] rounded;
    logic signed [CALC_W-1:0] narrowed;
    logic                     unused_hi;

    assign accept  = in_ready && data_valid;
    assign coef_wr = (state == IDLE) && coef_we;
    assign rd_idx  = wptr - k;
    assign mac_a   = sbuf[rd_idx];
    assign mac_b   = coef[k];
    assign warm    = (cnt == CW'(TAPS));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and MAC control.
    always_comb begin
        state_nxt = state;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (k == AW'(TAPS - 1)) begin
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                mac_clr   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Tap index, write pointer, saturating sample count and registered ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k        <= '0;
            wptr     <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
        end else begin
            in_ready <= (state_nxt == IDLE);
            if (state == MAC) begin
                k <= k + 1'b1;
            end else begin
                k <= '0;
            end
            if (state == ROUND) begin
                wptr <= wptr + 1'b1;
            end
            if (accept && (cnt != CW'(TAPS))) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Circular delay line, written at the accept edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                sbuf[AW'(i)] <= '0;
            end
        end else if (accept) begin
            sbuf[wptr] <= data;
        end
    end

    // Coefficient store, writable only while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                coef[AW'(i)] <= '0;
            end
        end else if (coef_wr) begin
            coef[coef_addr] <= coef_wdata;
        end
    end

    fir_stream_mac_unit #(
        .A_W   (DATA_W),
        .B_W   (COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (mac_a),
        .b   (mac_b),
        .sum (mac_sum)
    );

    // Rounding and narrowing of the completed sum.
    always_comb begin
        rounded = round_half_up(CALC_W'(mac_sum), FRAC);
`ifdef FIR_STREAM_SAT_EN
        narrowed = narrow_sat(rounded, OUT_W);
`else
        narrowed = narrow_wrap(rounded, OUT_W);
`endif
    end

    // Bits above OUT_W are only sign copies once narrowed.
    assign unused_hi = ^narrowed[CALC_W-1:OUT_W];

    // Output register: result captured in ROUND, pulse only once warm.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fir_d     <= '0;
            fir_valid <= 1'b0;
        end else begin
            fir_valid <= (state == ROUND) && warm;
            if (state == ROUND) begin
                fir_d <= narrowed[OUT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fir_stream_mac.sv
// Scoreboard bench for fir_stream_mac with a convolution reference model.
module tb_fir_stream_mac;

    localparam int DATA_W = 16;
    localparam int COEF_W = 18;
    localparam int FRAC   = 16;
    localparam int TAPS   = 32;
    localparam int OUT_W  = 16;
    localparam int AW     = 5;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     data_valid;
    logic signed [DATA_W-1:0] data;
    logic                     in_ready;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic signed [OUT_W-1:0]  fir_d;
    logic                     fir_valid;
    logic                     warm;

    fir_stream_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .FRAC   (FRAC),
        .TAPS   (TAPS),
        .OUT_W  (OUT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .data       (data),
        .in_ready   (in_ready),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .fir_d      (fir_d),
        .fir_valid  (fir_valid),
        .warm       (warm)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint val;
        int     due;
    } exp_t;

    exp_t   sb[$];
    longint hist [TAPS];
    longint hcoef [TAPS];
    int     mcnt;
    int     last_acc;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic longint model_out();
        longint acc;
        longint r;
        longint w;
        acc = 0;
        for (int i = 0; i < TAPS; i++) acc += hist[i] * hcoef[i];
        r = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
`ifdef FIR_STREAM_SAT_EN
        if (r > (longint'(1) <<< (OUT_W - 1)) - 1) r = (longint'(1) <<< (OUT_W - 1)) - 1;
        if (r < -(longint'(1) <<< (OUT_W - 1)))    r = -(longint'(1) <<< (OUT_W - 1));
        w = r;
`else
        w = r & ((longint'(1) <<< OUT_W) - 1);
        if (w >= (longint'(1) <<< (OUT_W - 1))) w -= (longint'(1) <<< OUT_W);
`endif
        return w;
    endfunction

    // Monitor and reference model, sampled mid-cycle.
    initial begin
        exp_t e;
        bit   busy;
        for (int i = 0; i < TAPS; i++) begin hist[i] = 0; hcoef[i] = 0; end
        mcnt = 0;
        last_acc = -1000;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_fir_d", fir_d, 0);
                chk("rst_fir_valid", fir_valid, 0);
                chk("rst_in_ready", in_ready, 0);
                chk("rst_warm", warm, 0);
                sb.delete();
                for (int i = 0; i < TAPS; i++) begin hist[i] = 0; hcoef[i] = 0; end
                mcnt = 0;
                last_acc = -1000;
            end else begin
                while (sb.size() > 0 && sb[0].due < cyc) begin
                    e = sb.pop_front();
                    n_chk++;
                    n_fail++;
                    $display("FAIL missing_fir_valid: got none, expected value %0d at cycle %0d", e.val, e.due);
                end
                if (fir_valid) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_fir_valid: got pulse fir_d=%0d at cycle %0d, expected none", fir_d, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("fir_d", fir_d, e.val);
                        chk("latency_cycle", cyc, e.due);
                    end
                end
                chk("warm", warm, (mcnt >= TAPS) ? 1 : 0);
                busy = (cyc >= last_acc + 1) && (cyc <= last_acc + TAPS + 1);
                if (busy) chk("in_ready_busy", in_ready, 0);
                if (cyc == last_acc + TAPS + 2) chk("in_ready_reopen", in_ready, 1);
                if (coef_we && !busy) hcoef[coef_addr] = coef_wdata;
                if (in_ready && data_valid) begin
                    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
                    hist[0] = data;
                    if (mcnt < TAPS) mcnt++;
                    if (mcnt >= TAPS) begin
                        e.val = model_out();
                        e.due = cyc + TAPS + 2;
                        sb.push_back(e);
                    end
                    last_acc = cyc;
                end
            end
        end
    end

    // One handshake: hold inputs until in_ready is seen, then drop them.
    task automatic xfer(input bit dv, input int x, input bit we, input int addr, input int cv);
        int t;
        t = 0;
        data_valid = dv;
        data       = x[DATA_W-1:0];
        coef_we    = we;
        coef_addr  = addr[AW-1:0];
        coef_wdata = cv[COEF_W-1:0];
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready=0 for 200 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        coef_we    = 1'b0;
    endtask

    task automatic send(input int x);
        xfer(1'b1, x, 1'b0, 0, 0);
    endtask

    task automatic wcoef(input int addr, input int cv);
        xfer(1'b0, 0, 1'b1, addr, cv);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by 2ms, expected completion");
        $fatal(1);
    end

    initial begin
        rst        = 1'b0;
        data_valid = 1'b0;
        data       = '0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Identity tap: outputs reproduce samples 32..40.
        wcoef(0, 'h10000);
        for (int i = 1; i <= 40; i++) send(i);

        // Moving average of a constant.
        do_reset();
        for (int i = 0; i < TAPS; i++) wcoef(i, 'h00800);
        for (int i = 0; i < 40; i++) send('h1000);

        // Full-scale accumulation beyond OUT_W.
        do_reset();
        for (int i = 0; i < TAPS; i++) wcoef(i, 'h10000);
        for (int i = 0; i < TAPS; i++) send('h7FFF);

        // Half-gain rounding on +3, -3, +1.
        do_reset();
        wcoef(0, 'h08000);
        for (int i = 0; i < TAPS - 1; i++) send(0);
        send(3);
        send(-3);
        send(1);

        // Sample and coefficient write during MAC are dropped.
        send(100);
        repeat (3) @(posedge clk);
        #1;
        chk("in_ready_mid_mac", in_ready, 0);
        data_valid = 1'b1;
        data       = 16'sd555;
        coef_we    = 1'b1;
        coef_addr  = '0;
        coef_wdata = 18'h20000;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        coef_we    = 1'b0;
        chk("in_ready_after_pulse", in_ready, 0);
        send(200);
        xfer(1'b1, 7, 1'b1, 0, 'h20000);

        // Randomised coefficients, samples, gaps and stray writes.
        do_reset();
        for (int i = 0; i < TAPS; i++) wcoef(i, int'($urandom));
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            if ($urandom_range(0, 3) == 0) begin
                #1;
                coef_we    = 1'b1;
                coef_addr  = AW'($urandom);
                coef_wdata = COEF_W'($urandom);
                @(posedge clk);
                #1 coef_we = 1'b0;
            end
            send(int'($urandom));
        end

        // Reset while the MAC is at tap 10.
        send(1234);
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_fir_d", fir_d, 0);
        chk("async_rst_fir_valid", fir_valid, 0);
        chk("async_rst_in_ready", in_ready, 0);
        chk("async_rst_warm", warm, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < TAPS; i++) wcoef(i, int'($urandom));
        for (int n = 0; n < TAPS + 3; n++) send(int'($urandom));

        repeat (TAPS + 6) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_stream_mac.md
Name: fir_stream_mac

Overview:
- Parametrised successor of the FAS front-end FIR stage: a streaming real-valued FIR filter with runtime-programmable coefficients.
- Uses one time-multiplexed multiply-accumulate unit and a valid/ready input handshake.
- Sits between the sample source and the FFT/peak-frequency stages; its output format matches the existing fir_d/fir_valid interface.

Parameters:
- DATA_W, 16, signed input sample width
- COEF_W, 18, signed coefficient width
- FRAC, 16, coefficient fractional bits; result is scaled by 2^-FRAC
- TAPS, 32, filter length; power of two, >=2
- OUT_W, 16, signed output width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- data_valid  in  1  input sample valid
- data  in  DATA_W  signed input sample
- in_ready  out  1  block can accept a sample this cycle
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  coefficient index k
- coef_wdata  in  COEF_W  signed coefficient h[k]
- fir_d  out  OUT_W  filtered sample
- fir_valid  out  1  one-cycle pulse, fir_d valid
- warm  out  1  delay line holds TAPS real samples

Behaviour:
- Reset (rst=0, async):
  - fir_d=0, fir_valid=0, in_ready=0, warm=0.
  - Delay line, coefficients, accumulator, sample counter and write pointer cleared to 0.
  - FSM returns to IDLE.
  - in_ready rises the first clk edge after rst deasserts.
- FSM states IDLE, MAC, ROUND:
  - IDLE: in_ready=1. data_valid=1 accepts the sample: it is written to buf[wptr], the sample count is latched, and the FSM goes to MAC with k=0.
  - MAC: in_ready=0, TAPS cycles. acc += buf[(wptr-k) mod TAPS] * h[k]; k counts 0..TAPS-1. Goes to ROUND after k=TAPS-1.
  - ROUND: in_ready=0. fir_d is registered, fir_valid pulses only if warm, wptr advances (wrapping TAPS-1 -> 0), acc clears, FSM returns to IDLE.
- Timing:
  - Sample accepted at edge t -> fir_valid high in cycle t+TAPS+2 (34 at defaults).
  - Throughput is one sample per TAPS+2 cycles.
  - data_valid while in_ready=0 is ignored; the sample is lost. The source must hold the sample until accepted.
- Arithmetic:
  - Accumulator width ACC_W = DATA_W+COEF_W+$clog2(TAPS), full precision, no overflow possible.
  - Rounding is round-half-up: (acc + 2^(FRAC-1)) >>> FRAC, arithmetic shift.
  - Narrowing to OUT_W follows the optional feature below.
- Warm-up:
  - Sample counter saturates at TAPS.
  - warm=1 once TAPS samples have been accepted; the TAPS-th sample produces the first fir_valid.
  - Earlier samples still run MAC/ROUND but never pulse fir_valid.
- Coefficients:
  - coef_we is honoured only in IDLE; writes in MAC/ROUND are dropped silently.
  - A write in the same IDLE cycle as a sample acceptance is visible to that sample's computation.
  - Coefficient writes do not clear the delay line or warm.
- Reset mid-operation: abandons the current computation with no fir_valid; warm-up restarts.

Optional Feature:
- Macro FIR_STREAM_SAT_EN.
- Defined: the rounded value is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: the rounded value is truncated to its low OUT_W bits (two's-complement wrap).

Decomposition:
- Package fir_stream_pkg holds:
  - FSM state enum (IDLE, MAC, ROUND)
  - function acc_width(DATA_W, COEF_W, TAPS)
  - round/narrow function (sat and wrap variants)
- One sub-module fir_stream_mac_unit:
  - registered signed multiply plus accumulate with clear and enable.
  - Its multiplier register is absorbed into the MAC-state cycle count, so the TAPS+2 latency stays unchanged.

Test Plan:
- Identity: h[0]=0x10000, others 0; feed samples 1..40 back-to-back on in_ready -> first fir_valid after sample 32 with fir_d=32, then 33..40; each pulse exactly 34 cycles after acceptance.
- Averager: all h=0x00800 (1/32), constant input 0x1000 -> no fir_valid for the first 31 samples, then fir_d=0x1000 on every subsequent output.
- Overflow: all h=0x10000, input 0x7FFF x32:
  - with FIR_STREAM_SAT_EN -> fir_d=0x7FFF
  - without -> fir_d=0xFFE0 (-32)
- Rounding: h[0]=0x08000 (0.5), warmed with zeros:
  - input 3 -> fir_d=2
  - input -3 -> fir_d=-1
  - input 1 -> fir_d=1
- Handshake/coef: pulse data_valid and coef_we(addr 0, 0x20000) during MAC:
  - both are ignored and in_ready stays 0
  - the same write in IDLE together with a sample accept takes effect for that sample
- Reset mid-MAC: drop rst at k=10 -> outputs 0 immediately, no fir_valid; after release, warm stays 0 until 32 new samples are accepted.
